uart_tx_core: RTL and testbench

UART transmit serializer, the transmit-side counterpart of rx_tick_gen.
- Consumes the one-cycle tick pulses from baud_generator, gated as baud_clk & en.
- Accepts a byte over a valid/ready handshake and shifts out start, data (LSB first), optional parity and stop bits on tx.
- Frame format uses 16550-style line-control fields; bit time is 16 or 13 ticks, selected by osm_sel.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_tx_core_if.sv | 14 +
 rtl/uart_tx_bit_timer.sv | 33 +++
 rtl/uart_tx_core.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_core.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared types, codes and helpers for the UART TX core  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam logic [5:0] TICKS_16 = 6'd16;
  localparam logic [5:0] TICKS_13 = 6'd13;

  // Stop duration in ticks: N, N + N/2 (5-bit words) or 2N.
  function automatic logic [5:0] stop_ticks(input logic stb, input logic [1:0] wls,
                                            input logic [5:0] n);
    if (!stb) begin
      return n;
    end
    if (wls == WLS_5) begin
      return n + {1'b0, n[5:1]};
    end
    return {n[4:0], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_core_if : byte valid/ready handshake into the TX core    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_tx_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_bit_timer : counts baud ticks, pulses at segment end     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_bit_timer #(
  parameter int CNT_W = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             baud_tick,
  input  wire logic [CNT_W-1:0] target,
  output logic                  bit_end
);

  logic [CNT_W-1:0] count;

  // A tick that lands while clearing (idle / accept / abort) is never counted.
  assign bit_end = baud_tick & ~clr & (count == (target - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || bit_end) begin
      count <= '0;
    end else if (baud_tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_core : UART transmit serializer with 16550-style framing |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_core #(
  parameter logic [5:0] TICKS_16 = 6'd16,
  parameter logic [5:0] TICKS_13 = 6'd13
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       baud_tick,
  input  wire logic       osm_sel,
  input  wire logic [1:0] wls,
  input  wire logic       stb,
  input  wire logic       pen,
  input  wire logic       eps,
  input  wire logic       sp,
  input  wire logic       brk,
  input  wire logic       tx_clr,
  uart_tx_core_if.slave   txif,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  import uart_pkg::*;

  tx_state_t  state, state_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] wls_q, wls_d;
  logic       stb_q, stb_d;
  logic       pen_q, pen_d;
  logic       eps_q, eps_d;
  logic       sp_q, sp_d;
  logic [5:0] n_q, n_d;

  logic       timer_clr;
  logic       bit_end;
  logic [5:0] target;
  logic [7:0] data_mask;
  logic [7:0] data_bits;
  logic       parity_bit;
  logic       last_data_bit;

  assign target        = (state == STOP) ? stop_ticks(stb_q, wls_q, n_q) : n_q;
  assign data_mask     = 8'hFF >> (2'd3 - wls_q);
  assign data_bits     = data_q & data_mask;
  assign parity_bit    = sp_q ? ~eps_q : (eps_q ? ^data_bits : ~^data_bits);
  assign last_data_bit = (bit_idx_q == ({1'b0, wls_q} + 3'd4));

  uart_tx_bit_timer #(.CNT_W(6)) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (timer_clr),
    .baud_tick (baud_tick),
    .target    (target),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d   = state;
    tx_d      = tx_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    wls_d     = wls_q;
    stb_d     = stb_q;
    pen_d     = pen_q;
    eps_d     = eps_q;
    sp_d      = sp_q;
    n_d       = n_q;
    timer_clr = 1'b0;

    case (state)
      IDLE: begin
        timer_clr = 1'b1;
        tx_d      = 1'b1;
        if (txif.tx_valid) begin
          data_d    = txif.tx_data;
          shift_d   = txif.tx_data;
          wls_d     = wls;
          stb_d     = stb;
          pen_d     = pen;
          eps_d     = eps;
          sp_d      = sp;
          n_d       = osm_sel ? TICKS_13 : TICKS_16;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data_bit) begin
            state_d = pen_q ? PARITY : STOP;
            tx_d    = pen_q ? parity_bit : 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Abort overrides everything, including a frame end on the same edge.
    if (tx_clr) begin
      state_d   = IDLE;
      tx_d      = 1'b1;
      done_d    = 1'b0;
      timer_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      bit_idx_q <= 3'd0;
      wls_q     <= WLS_8;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      sp_q      <= 1'b0;
      n_q       <= TICKS_16;
    end else begin
      state     <= state_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      wls_q     <= wls_d;
      stb_q     <= stb_d;
      pen_q     <= pen_d;
      eps_q     <= eps_d;
      sp_q      <= sp_d;
      n_q       <= n_d;
    end
  end

  assign txif.tx_ready = (state == IDLE);
  assign tx_busy       = (state != IDLE);
  assign tx_done       = done_q;
  assign tx            = tx_q & ~brk;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_core : frame-level model bench for uart_tx_core       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       osm_sel = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic       brk = 1'b0;
  logic       tx_clr = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 0;

  uart_tx_core_if txif();

  uart_tx_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .osm_sel   (osm_sel),
    .wls       (wls),
    .stb       (stb),
    .pen       (pen),
    .eps       (eps),
    .sp        (sp),
    .brk       (brk),
    .tx_clr    (tx_clr),
    .txif      (txif),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #10 clk = ~clk;

  // Baud tick every 5 clocks, changed just after the edge.
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (div == 4) begin
        div = 0;
        baud_tick = 1'b1;
      end else begin
        div++;
        baud_tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Frame model: a queue of (line level, duration in counted ticks) segments.
  bit m_busy = 0;
  bit m_txq = 1;
  bit m_done = 0;
  bit seg_lvl[$];
  int seg_len[$];

  function automatic void build_frame(input logic [7:0] d);
    int n  = osm_sel ? 13 : 16;
    int nb = int'(wls) + 5;
    int ones = 0;
    bit par;
    seg_lvl.delete();
    seg_len.delete();
    seg_lvl.push_back(1'b0);
    seg_len.push_back(n);
    for (int i = 0; i < nb; i++) begin
      seg_lvl.push_back(d[i]);
      seg_len.push_back(n);
      ones += int'(d[i]);
    end
    if (pen) begin
      if (sp) par = !eps;
      else if (eps) par = (ones % 2 == 1);
      else par = (ones % 2 == 0);
      seg_lvl.push_back(par);
      seg_len.push_back(n);
    end
    seg_lvl.push_back(1'b1);
    if (!stb) seg_len.push_back(n);
    else if (nb == 5) seg_len.push_back(n + n / 2);
    else seg_len.push_back(2 * n);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n || tx_clr) begin
        m_busy = 0;
        m_txq  = 1;
        m_done = 0;
        seg_lvl.delete();
        seg_len.delete();
      end else begin
        m_done = 0;
        if (!m_busy) begin
          if (txif.tx_valid) begin
            build_frame(txif.tx_data);
            m_busy = 1;
            m_txq  = seg_lvl[0];
          end
        end else if (baud_tick) begin
          seg_len[0] = seg_len[0] - 1;
          if (seg_len[0] == 0) begin
            void'(seg_lvl.pop_front());
            void'(seg_len.pop_front());
            if (seg_lvl.size() == 0) begin
              m_busy = 0;
              m_done = 1;
              m_txq  = 1;
            end else begin
              m_txq = seg_lvl[0];
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("tx", tx, m_txq & ~brk);
        check("tx_ready", txif.tx_ready, !m_busy);
        check("tx_busy", tx_busy, m_busy);
        check("tx_done", tx_done, m_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic [7:0] d);
    int t = 0;
    txif.tx_data  = d;
    txif.tx_valid = 1'b1;
    while (txif.tx_ready !== 1'b1 && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) check_int("accept_timeout", t, 0);
    step();
    txif.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int c);
    c = 0;
    while (tx_done !== 1'b1 && c < limit) begin
      step();
      c++;
    end
    if (c >= limit) check_int("done_timeout", c, 0);
  endtask

  // Sample each bit near its centre and time tx_done against the tick count.
  task automatic send_frame(input string name, input logic [7:0] d, input int bpc, input int nb,
                            input logic [11:0] exp_bits, input int ticks);
    int c = 0;
    int k = 0;
    int done_c = -1;
    int ndone = 0;
    accept(d);
    while (c < ticks * 5 + 30) begin
      step();
      c++;
      if (k < nb && c == bpc / 2 + bpc * k) begin
        check($sformatf("%s_bit%0d", name, k), tx, exp_bits[k]);
        k++;
      end
      if (tx_done === 1'b1) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
    end
    check_int({name, "_done_count"}, ndone, 1);
    check_rng({name, "_done_time"}, done_c, 5 * ticks - 5, 5 * ticks);
  endtask

  initial begin
    int c;
    int nd;
    txif.tx_data  = 8'h00;
    txif.tx_valid = 1'b0;

    // Reset and idle
    rst_n = 1'b0;
    step();
    chk_en = 1;
    step();
    rst_n = 1'b1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", txif.tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    repeat (200) step();
    check("idle_tx", tx, 1'b1);
    check("idle_ready", txif.tx_ready, 1'b1);

    // 8N1, 0xA5
    osm_sel = 0; wls = 2'b11; pen = 0; stb = 0; eps = 0; sp = 0;
    send_frame("8n1", 8'hA5, 80, 10, 12'b00_1101001010, 160);

    // 7E2, 0x5A, 13 ticks/bit
    osm_sel = 1; wls = 2'b10; pen = 1; eps = 1; stb = 1; sp = 0;
    send_frame("7e2", 8'h5A, 65, 11, 12'b0_11010110100, 143);

    // 5-bit stick parity, 1.5 stop bits
    osm_sel = 0; wls = 2'b00; pen = 1; sp = 1; eps = 0; stb = 1;
    send_frame("5s15", 8'hFF, 80, 8, 12'b0000_1111_1110, 136);

    // Back-to-back with tx_valid held
    osm_sel = 0; wls = 2'b11; pen = 0; stb = 0; sp = 0;
    txif.tx_data  = 8'h11;
    txif.tx_valid = 1'b1;
    step();
    txif.tx_data = 8'h22;
    wait_done(1200, c);
    step();
    check("b2b_start_tx", tx, 1'b0);
    check("b2b_start_busy", tx_busy, 1'b1);
    txif.tx_valid = 1'b0;
    wait_done(1200, c);
    check_rng("b2b_second_done", c, 794, 800);
    step();

    // Abort mid-DATA
    accept(8'hF0);
    repeat (300) step();
    tx_clr = 1'b1;
    step();
    tx_clr = 1'b0;
    check("clr_tx", tx, 1'b1);
    check("clr_ready", txif.tx_ready, 1'b1);
    nd = 0;
    repeat (1000) begin
      step();
      if (tx_done === 1'b1) nd++;
    end
    check_int("clr_no_done", nd, 0);

    // Break held across a whole frame
    brk = 1'b1;
    accept(8'h3C);
    check("brk_tx_low", tx, 1'b0);
    wait_done(1200, c);
    check_rng("brk_done_time", c, 794, 800);
    brk = 1'b0;
    step();

    // Randomised frames with mid-frame config churn and occasional aborts
    for (int f = 0; f < 14; f++) begin
      osm_sel = 1'($urandom_range(0, 1));
      wls     = 2'($urandom_range(0, 3));
      stb     = 1'($urandom_range(0, 1));
      pen     = 1'($urandom_range(0, 1));
      eps     = 1'($urandom_range(0, 1));
      sp      = 1'($urandom_range(0, 1));
      brk     = ($urandom_range(0, 5) == 0);
      accept(8'($urandom_range(0, 255)));
      osm_sel = 1'($urandom_range(0, 1));
      wls     = 2'($urandom_range(0, 3));
      stb     = 1'($urandom_range(0, 1));
      pen     = 1'($urandom_range(0, 1));
      eps     = 1'($urandom_range(0, 1));
      sp      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 600)) step();
        tx_clr = 1'b1;
        step();
        tx_clr = 1'b0;
      end else begin
        wait_done(1500, c);
      end
      brk = 1'b0;
      repeat ($urandom_range(0, 40)) step();
    end

    repeat (20) step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
